// File: rtl/s_eta_pack.sv
// Streams the eta=2 secret-vector memory out as 3-bit BitPack codes.
// It reads two coefficients per cycle and emits one 24-bit word for every 8 coefficients.
module s_eta_pack #(
  parameter int          NUM_POLY = 4,
  parameter logic [22:0] Q        = 23'd8380417
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [9:0]  raddr_z0,
  output logic [9:0]  raddr_z1,
  output logic        ren_z,
  input  logic [22:0] rdata_z0,
  input  logic [22:0] rdata_z1,
  output logic [23:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] LAST_POLY = 2'(NUM_POLY - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PUSH,
    DONE_S
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  poly;
  logic [4:0]  word;
  logic [2:0]  pair;
  logic [23:0] word_q;
  logic [2:0]  enc0, enc1;
  logic [9:0]  addr_base;
  logic        handshake;
  logic        last_word;

  // Codes are eta - c, with negative c held as Q - |c|; anything else is flagged as 7.
  function automatic logic [2:0] encode(input logic [22:0] v);
    logic [2:0] code;
    if (v == 23'd0)            code = 3'd2;
    else if (v == 23'd1)       code = 3'd1;
    else if (v == 23'd2)       code = 3'd0;
    else if (v == Q - 23'd1)   code = 3'd3;
    else if (v == Q - 23'd2)   code = 3'd4;
    else                       code = 3'd7;
    return code;
  endfunction

  assign enc0      = encode(rdata_z0);
  assign enc1      = encode(rdata_z1);
  assign handshake = (state == PUSH) && out_ready;
  assign last_word = (word == 5'd31) && (poly == LAST_POLY);
  assign addr_base = {poly, word, pair[1:0], 1'b0};

  // Addresses are gated by ren_z so that they read back as zero whenever no read is in flight.
  assign raddr_z0  = ren_z ? addr_base : 10'd0;
  assign raddr_z1  = ren_z ? addr_base + 10'd1 : 10'd0;
  assign out_word  = word_q;
  assign out_last  = (state == PUSH) && (word == 5'd31);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    ren_z     = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nx = FETCH;
      end
      FETCH: begin
        if (pair != 3'd4) ren_z = 1'b1;
        else              state_nx = PUSH;
      end
      PUSH: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = last_word ? DONE_S : FETCH;
      end
      DONE_S: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Read data for pair p-1 lands during pair p and fills slots 2(p-1) and 2(p-1)+1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      poly   <= 2'd0;
      word   <= 5'd0;
      pair   <= 3'd0;
      word_q <= 24'd0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            poly <= 2'd0;
            word <= 5'd0;
            pair <= 3'd0;
            err  <= 1'b0;
          end
        end
        FETCH: begin
          if (pair != 3'd4) pair <= pair + 3'd1;
          case (pair)
            3'd1:    word_q[5:0]   <= {enc1, enc0};
            3'd2:    word_q[11:6]  <= {enc1, enc0};
            3'd3:    word_q[17:12] <= {enc1, enc0};
            3'd4:    word_q[23:18] <= {enc1, enc0};
            default: ;
          endcase
          if (pair != 3'd0 && (enc0 == 3'd7 || enc1 == 3'd7)) err <= 1'b1;
        end
        PUSH: begin
          if (handshake && !last_word) begin
            pair <= 3'd0;
            word <= word + 5'd1;
            if (word == 5'd31) poly <= poly + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_s_eta_pack.sv
// Directed bench for s_eta_pack: a one-cycle-latency memory model, a consumer with stall,
// and a reset/restart sequence. Expected words are hand-computed constants.
module tb_s_eta_pack;

  localparam logic [22:0] Q = 23'd8380417;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  raddr_z0, raddr_z1;
  logic        ren_z;
  logic [22:0] rdata_z0 = 23'd0;
  logic [22:0] rdata_z1 = 23'd0;
  logic [23:0] out_word;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        busy, done, err;

  logic [22:0] mem [0:1023];
  logic [22:0] pat [0:7];
  int tests_run = 0;
  int tests_failed = 0;

  s_eta_pack #(.NUM_POLY(4), .Q(Q)) dut (
    .clk(clk), .reset(reset), .start(start),
    .raddr_z0(raddr_z0), .raddr_z1(raddr_z1), .ren_z(ren_z),
    .rdata_z0(rdata_z0), .rdata_z1(rdata_z1),
    .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Memory returns data the cycle after ren_z.
  always @(posedge clk) begin
    if (ren_z) begin
      rdata_z0 <= mem[raddr_z0];
      rdata_z1 <= mem[raddr_z1];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // mode 0: all zero, 1: all Q-2, 2: repeating pattern, 3: zero except one bad coefficient
  task automatic fillMem(input int mode);
    for (int i = 0; i < 1024; i++) begin
      case (mode)
        1:       mem[i] = Q - 23'd2;
        2:       mem[i] = pat[i % 8];
        default: mem[i] = 23'd0;
      endcase
    end
    if (mode == 3) mem[273] = 23'd3;
  endtask

  task automatic applyStimulus(input int mode);
    fillMem(mode);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("first_ren", 32'(ren_z), 32'd1);
    checkOutput("first_addr0", 32'(raddr_z0), 32'd0);
    checkOutput("first_addr1", 32'(raddr_z1), 32'd1);
  endtask

  function automatic logic [23:0] expWord(input int mode, input int idx);
    logic [23:0] w;
    case (mode)
      1:       w = 24'h924924;
      2:       w = 24'h05460A;
      3:       w = (idx == 34) ? 24'h4924BA : 24'h492492;
      default: w = 24'h492492;
    endcase
    return w;
  endfunction

  task automatic consumeStream(input int mode, input bit stall_first, input int pulse_idx);
    int cnt;
    logic [23:0] exp_word;
    cnt = 1;
    for (int idx = 0; idx < 128; idx++) begin
      while (!out_valid && cnt < 60) begin
        @(negedge clk);
        cnt++;
      end
      if (!out_valid) begin
        checkOutput("valid_timeout", 32'd0, 32'd1);
        return;
      end
      if (idx == 0) checkOutput("latency", 32'(cnt), 32'd6);
      exp_word = expWord(mode, idx);
      if (stall_first && idx == 0) begin
        for (int s = 0; s < 10; s++) begin
          @(negedge clk);
          checkOutput("stall_valid", 32'(out_valid), 32'd1);
          checkOutput("stall_ren", 32'(ren_z), 32'd0);
          checkOutput("stall_word", 32'(out_word), 32'(exp_word));
        end
        out_ready = 1'b1;
      end
      checkOutput($sformatf("word%0d", idx), 32'(out_word), 32'(exp_word));
      checkOutput($sformatf("last%0d", idx), 32'(out_last), 32'((idx % 32) == 31));
      if (mode == 3 && idx == 33) checkOutput("err_before", 32'(err), 32'd0);
      if (mode == 3 && idx == 34) checkOutput("err_rise", 32'(err), 32'd1);
      @(negedge clk);
      cnt = 1;
      if (idx == pulse_idx) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 2;
      end
    end
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("busy_in_done", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("done_clear", 32'(done), 32'd0);
    checkOutput("busy_idle", 32'(busy), 32'd0);
    checkOutput("err_final", 32'(err), 32'(mode == 3));
  endtask

  task automatic resetMidRun();
    int cnt;
    fillMem(0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!(ren_z && raddr_z0[7:3] == 5'd5) && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("word5_reached", 32'(ren_z && raddr_z0[7:3] == 5'd5), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("rst_ren", 32'(ren_z), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_word", 32'(out_word), 32'd0);
    checkOutput("rst_addr0", 32'(raddr_z0), 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    pat[0] = 23'd0;      pat[1] = 23'd1;      pat[2] = 23'd2;  pat[3] = Q - 23'd1;
    pat[4] = Q - 23'd2;  pat[5] = 23'd0;      pat[6] = 23'd1;  pat[7] = 23'd2;
    fillMem(0);
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_ren", 32'(ren_z), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_last", 32'(out_last), 32'd0);
    checkOutput("reset_word", 32'(out_word), 32'd0);
    checkOutput("reset_addr1", 32'(raddr_z1), 32'd0);
    reset = 1'b1;

    out_ready = 1'b0;
    applyStimulus(0);
    consumeStream(0, 1'b1, -1);

    applyStimulus(1);
    consumeStream(1, 1'b0, -1);

    applyStimulus(2);
    consumeStream(2, 1'b0, -1);

    applyStimulus(3);
    consumeStream(3, 1'b0, -1);

    resetMidRun();
    applyStimulus(3);
    consumeStream(3, 1'b0, 3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
